ssd_scan_display: RTL and testbench
===================================

# ssd_scan_display

Time-multiplexed seven-segment display controller for an N-digit common-anode board. In mode 0 it shows N raw hex nibbles. In mode 1 it shows a W-bit two's-complement result as a sign plus right-aligned hex magnitude, with leading-zero blanking. It drives one shared segment bus and per-digit enables from a scan counter. Inputs are snapshotted once per frame so the display never tears. It sits between the datapath (rollers, calculator) and the board pins, replacing the per-digit static encoders.

## Interface
- `N_DIGITS`, 4, number of digits; digit 0 is rightmost.
- `W`, 8, signed value width; requires `N_DIGITS >= ceil(W/4)+1`, otherwise elaboration fails via `$error`.
- `SCAN_DIV`, 50000, clock cycles per digit slot; must be at least 1.
- `BLINK_FRAMES`, 64, frames per blink half-period; used only with `SSD_BLINK_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `raw`  in  4*N_DIGITS  mode-0 nibbles; digit i is `raw[4i+3:4i]`.
- `value`  in  W  mode-1 signed value.
- `overflow`  in  1  calculator overflow flag.
- `m`  in  1  mode select (0 = raw, 1 = signed value).
- `seg`  out  7  active-low segments, ordered {g,f,e,d,c,b,a}; registered.
- `an`  out  N_DIGITS  active-low digit enables, one-hot-low; registered.
- `overflow_led`  out  1  registered; equals snapshot `m & overflow`.

## Operation
- Scan counter `cnt` runs 0..SCAN_DIV-1. At the terminal count, digit index `idx` advances 0..N_DIGITS-1 and wraps.
- Frame start is the edge where `cnt==0` and `idx==0`, including the first edge after reset release.
- At frame start, `raw`, `value`, `overflow` and `m` load into snapshot registers.
- On the frame-start edge, `seg` is computed from the live inputs being captured, so the frame is consistent from its first cycle.
- Glyphs use 0–F hex with lowercase b and d. Examples: 0 = 1000000, 1 = 1111001, 5 = 0010010, 8 = 0000000, A = 0001000, F = 0001110. Minus = 0111111. Blank = 1111111.
- Mode 0: digit i shows the glyph of snapshot nibble i.
- Mode 1:
  - The magnitude is `|value|`, computed at W bits unsigned; the most-negative value maps to 2^(W-1).
  - The magnitude occupies digits 0..ceil(W/4)-1.
  - Leading zero digits are blanked; digit 0 is always shown.
  - If negative, minus is placed in the digit immediately left of the most-significant shown digit.
  - All other digits are blank.
- `overflow_led` updates only at frame start.

## Timing
- Reset (asynchronous, immediate, including mid-frame):
  - `cnt=0`, `idx=0`.
  - Snapshot cleared: all zero, `m=0`.
  - `an` = all ones, `seg=1111111`, `overflow_led=0`.
- First edge after release: `an = ~1` (digit 0), `seg` = glyph of the live digit 0.
- Each digit is enabled for exactly SCAN_DIV cycles; a frame is N_DIGITS*SCAN_DIV cycles.
- `an` and `seg` change on the same edge, one edge after `idx` changes. There is no ghosting cycle with two digits enabled.
- Input or `m` changes mid-frame are invisible until the next frame start. A change on the frame-start edge itself is captured.
- With SCAN_DIV=1, the digit advances every cycle.

## Configuration
- `SSD_BLINK_EN` defined:
  - A frame counter toggles blink phase every BLINK_FRAMES frames.
  - While snapshot `m & overflow` is 1 and phase is 1, `an` is forced to all ones and scanning continues.
  - Phase resets to 0 and its counter clears when the snapshot overflow is 0.
  - `overflow_led` stays steady and does not blink.
- `SSD_BLINK_EN` undefined:
  - No blink logic is present.
  - The display is always steady; `overflow_led` behaviour is unchanged.

## Test plan
- Reset, `m=0`, `raw=16'h3A50`, SCAN_DIV=4. Required, over digits 0..3 for 4 cycles each: `an` = 1110/1101/1011/0111 and `seg` = 1000000 / 0010010 / 0001000 / 0110000.
- `m=1`, W=8, `value=8'hFB` (-5). Required: digit0 = 5, digit1 = minus, digits 2–3 blank.
- `value=8'h80`. Required: digit0 = 0, digit1 = 8, digit2 = minus, digit3 blank. `value=8'h00` shows digit0 = 0 with all other digits blank.
- Change `raw` from 16'h1111 to 16'h2222 while digit 2 is lit. Required: digit 3 still shows 1; the next frame shows all 2s.
- Assert `rst_n=0` mid-slot. Required: `an=1111`, `seg=1111111`, `overflow_led=0` immediately, without waiting for a clock edge.
- `m=1`, `overflow=1`, BLINK_FRAMES=2, with `SSD_BLINK_EN`. Required: `overflow_led=1` from the next frame start, and `an` is all ones during frames 2–3, 6–7 and so on. Without the macro, `an` never blanks.

Source files
------------

// File: rtl/ssd_scan_display_if.sv
// Display bus: datapath-side inputs (raw nibbles, signed value, flags) and board-side
// outputs (segments, digit enables, overflow LED) of the seven-segment scan controller.
interface ssd_scan_display_if #(
  parameter int N_DIGITS = 4,
  parameter int W        = 8
);
  logic [4*N_DIGITS-1:0] raw;
  logic [W-1:0]          value;
  logic                  overflow;
  logic                  m;
  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   an;
  logic                  overflow_led;

  modport master (output raw, value, overflow, m, input seg, an, overflow_led);
  modport slave  (input raw, value, overflow, m, output seg, an, overflow_led);
endinterface

// File: rtl/ssd_scan_display.sv
// Time-multiplexed common-anode seven-segment controller: raw hex (m=0) or signed
// sign+magnitude with leading-zero blanking (m=1). Optional overflow blink: SSD_BLINK_EN.
module ssd_scan_display #(
  parameter int N_DIGITS     = 4,
  parameter int W            = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  ssd_scan_display_if.slave   bus
);

  localparam int MAG_DIGITS = (W + 3) / 4;
  localparam int RAW_W      = 4 * N_DIGITS;
  localparam int CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  if (N_DIGITS < MAG_DIGITS + 1) begin : g_bad_digits
    $error("ssd_scan_display: N_DIGITS=%0d too small for W=%0d plus sign", N_DIGITS, W);
  end
  if (SCAN_DIV < 1) begin : g_bad_div
    $error("ssd_scan_display: SCAN_DIV must be at least 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("ssd_scan_display: BLINK_FRAMES must be at least 1");
  end

  typedef struct packed {
    logic [RAW_W-1:0] raw;
    logic [W-1:0]     value;
    logic             overflow;
    logic             m;
  } frame_t;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cnt_last;
  logic             idx_last;
  logic             frame_start;

  frame_t live;
  frame_t snap;
  frame_t src;

  assign cnt_last    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_last    = (idx == IDX_W'(N_DIGITS - 1));
  assign frame_start = (cnt == '0) && (idx == '0);

  assign live = '{raw: bus.raw, value: bus.value, overflow: bus.overflow, m: bus.m};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The frame-start edge renders from the inputs being captured, not the stale snapshot.
  assign src = frame_start ? live : snap;

  logic [W-1:0]     mag;
  logic [RAW_W-1:0] mag_ext;
  logic [IDX_W-1:0] msd;
  logic             neg;
  logic [6:0]       seg_signed;
  logic [6:0]       seg_next;
  logic [N_DIGITS-1:0] an_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    neg     = src.value[W-1];
    mag     = neg ? (-src.value) : src.value;
    mag_ext = RAW_W'(mag);
    msd     = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (mag_ext[4*k +: 4] != 4'h0) msd = IDX_W'(k);
    end

    if (idx <= msd)                           seg_signed = hex_glyph(mag_ext[{idx, 2'b00} +: 4]);
    else if (neg && (idx == msd + IDX_W'(1))) seg_signed = SEG_MINUS;
    else                                      seg_signed = SEG_BLANK;

    seg_next = src.m ? seg_signed : hex_glyph(src.raw[{idx, 2'b00} +: 4]);
    an_next  = ~(N_DIGITS'(1) << idx);
  end

  logic blank;

`ifdef SSD_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic            phase;
  logic            phase_d;
  logic [BF_W-1:0] fcnt;
  logic [BF_W-1:0] fcnt_d;

  // Phase advances only across consecutive overflow frames; any clear frame restarts it.
  always_comb begin
    phase_d = phase;
    fcnt_d  = fcnt;
    if (frame_start) begin
      if (!(live.m & live.overflow)) begin
        phase_d = 1'b0;
        fcnt_d  = '0;
      end else if (snap.m & snap.overflow) begin
        if (fcnt == BF_W'(BLINK_FRAMES - 1)) begin
          fcnt_d  = '0;
          phase_d = ~phase;
        end else begin
          fcnt_d = fcnt + 1'b1;
        end
      end
    end
    blank = src.m & src.overflow & phase_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      fcnt  <= '0;
    end else begin
      phase <= phase_d;
      fcnt  <= fcnt_d;
    end
  end
`else
  assign blank = 1'b0;
`endif

  // NOTE: the snapshot is a handful of flops, not a memory, so it is reset to a defined frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap             <= '0;
      bus.seg          <= SEG_BLANK;
      bus.an           <= '1;
      bus.overflow_led <= 1'b0;
    end else begin
      bus.seg <= seg_next;
      bus.an  <= blank ? '1 : an_next;
      if (frame_start) begin
        snap             <= live;
        bus.overflow_led <= live.m & live.overflow;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_display.sv
// Directed bench for ssd_scan_display: per-frame expected outputs are queued when the
// inputs are driven and popped each cycle as the DUT scans.
module tb_ssd_scan_display;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SD = 4;
  localparam int BF = 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssd_scan_display_if #(.N_DIGITS(N), .W(W)) bus ();

  ssd_scan_display #(
    .N_DIGITS(N), .W(W), .SCAN_DIV(SD), .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         led;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   ovf_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] exp_digit(input logic [15:0] r, input logic [7:0] v,
                                           input logic mode, input int d);
    int sv, mag, nd;
    if (!mode) return GLYPH[int'(r[4*d +: 4])];
    sv  = int'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    nd  = 1;
    while ((mag >> (4*nd)) != 0) nd++;
    if (d < nd) return GLYPH[(mag >> (4*d)) & 15];
    if (sv < 0 && d == nd) return MINUS;
    return BLANK;
  endfunction

  // Drives one frame's inputs before its start edge, queues the expected scan, then
  // checks every cycle; chg_cyc >= 0 rewrites raw mid-frame (must stay invisible).
  task automatic run_frame(input logic [15:0] r, input logic [7:0] v, input logic of,
                           input logic mode, input int chg_cyc, input logic [15:0] chg_raw,
                           input string tag);
    logic ovf, blank;
    exp_t e, got;
    bus.raw      = r;
    bus.value    = v;
    bus.overflow = of;
    bus.m        = mode;
    ovf   = mode & of;
    blank = 1'b0;
    if (ovf) begin
`ifdef SSD_BLINK_EN
      blank = ((ovf_frames / BF) % 2) == 1;
`endif
      ovf_frames++;
    end else begin
      ovf_frames = 0;
    end
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < SD; c++) begin
        e.an  = blank ? '1 : ~(N'(1) << d);
        e.seg = exp_digit(r, v, mode, d);
        e.led = ovf;
        sb.push_back(e);
      end
    end
    for (int k = 0; k < N*SD; k++) begin
      @(posedge clk);
      #1;
      if (k == chg_cyc) bus.raw = chg_raw;
      got = sb.pop_front();
      check($sformatf("%s d%0d c%0d", tag, k / SD, k % SD),
            32'({bus.an, bus.seg, bus.overflow_led}), 32'({got.an, got.seg, got.led}));
    end
  endtask

  initial begin
    bus.raw      = '0;
    bus.value    = '0;
    bus.overflow = 1'b0;
    bus.m        = 1'b0;

    #12;
    check("reset_an",  32'(bus.an),           32'hF);
    check("reset_seg", 32'(bus.seg),          32'h7F);
    check("reset_led", 32'(bus.overflow_led), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(16'h3A50, 8'h00, 1'b0, 1'b0, -1, 16'h0, "raw3A50");
    run_frame(16'hFEDC, 8'h00, 1'b0, 1'b0, -1, 16'h0, "rawFEDC");
    run_frame(16'hB987, 8'h00, 1'b0, 1'b0, -1, 16'h0, "rawB987");
    run_frame(16'h6421, 8'h00, 1'b0, 1'b0, -1, 16'h0, "raw6421");

    run_frame(16'h0000, 8'hFB, 1'b0, 1'b1, -1, 16'h0, "valFB");
    run_frame(16'h0000, 8'h80, 1'b0, 1'b1, -1, 16'h0, "val80");
    run_frame(16'h0000, 8'h00, 1'b0, 1'b1, -1, 16'h0, "val00");
    run_frame(16'h0000, 8'h7F, 1'b0, 1'b1, -1, 16'h0, "val7F");
    run_frame(16'h0000, 8'h0F, 1'b0, 1'b1, -1, 16'h0, "val0F");
    run_frame(16'h0000, 8'hF1, 1'b0, 1'b1, -1, 16'h0, "valF1");
    run_frame(16'h0000, 8'h10, 1'b0, 1'b1, -1, 16'h0, "val10");
    run_frame(16'h0000, 8'hFF, 1'b0, 1'b1, -1, 16'h0, "valFF");

    run_frame(16'h1111, 8'h00, 1'b0, 1'b0, 2*SD + 1, 16'h2222, "tear1111");
    run_frame(16'h2222, 8'h00, 1'b0, 1'b0, -1, 16'h0, "next2222");

    run_frame(16'h5555, 8'h05, 1'b1, 1'b0, -1, 16'h0, "ovf_m0");

    for (int f = 0; f < 8; f++)
      run_frame(16'h0000, 8'hFB, 1'b1, 1'b1, -1, 16'h0, $sformatf("ovf_f%0d", f));
    run_frame(16'h0000, 8'hFB, 1'b0, 1'b1, -1, 16'h0, "ovf_clear");
    run_frame(16'h0000, 8'h80, 1'b1, 1'b1, -1, 16'h0, "ovf_again");

    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_an",  32'(bus.an),           32'hF);
    check("midreset_seg", 32'(bus.seg),          32'h7F);
    check("midreset_led", 32'(bus.overflow_led), 32'h0);
    @(posedge clk);
    #1;
    check("held_an",  32'(bus.an),  32'hF);
    check("held_seg", 32'(bus.seg), 32'h7F);
    ovf_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(16'h3A50, 8'h00, 1'b0, 1'b0, -1, 16'h0, "after_rst");
    run_frame(16'h0000, 8'hFB, 1'b1, 1'b1, -1, 16'h0, "after_rst_ovf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
